// File: rtl/md_pad_responder.sv
// Device-side Mega Drive 3/6-button pad: answers the host select line with
// the active-low data pattern for the current select level and sequence step.
module md_pad_responder #(
  parameter int TIMEOUT = 75000,
  parameter int SIX_BTN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] btn,
  input  logic        mdsel,
  output logic [5:0]  pad_out,
  output logic [2:0]  phase
);

  localparam logic [16:0] T_LAST = 17'(TIMEOUT - 1);
  localparam bit          SIX    = (SIX_BTN != 0);

  logic        sel_m, sel_s, sel_d;
  logic        fall, rise, sel_edge;
  logic [2:0]  n;
  logic [16:0] t;
  logic [5:0]  pad_nxt;
  logic        b_m, b_s, b_z, b_y, b_x, b_c, b_b, b_a, b_u, b_d, b_l, b_r;

  assign {b_m, b_s, b_z, b_y, b_x, b_c, b_b, b_a, b_u, b_d, b_l, b_r} = btn;

  // Select idles high, so the synchronizer resets to 1 and a low select
  // seen right after reset is counted as a fresh fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_m <= 1'b1;
      sel_s <= 1'b1;
      sel_d <= 1'b1;
    end else begin
      sel_m <= mdsel;
      sel_s <= sel_m;
      sel_d <= sel_s;
    end
  end

  assign fall     = sel_d & ~sel_s;
  assign rise     = ~sel_d & sel_s;
  assign sel_edge = fall | rise;

  // An edge landing on the timeout cycle takes priority over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      n <= 3'd0;
      t <= 17'd0;
    end else if (sel_edge) begin
      t <= 17'd0;
      if (fall && n < 3'd4) n <= n + 3'd1;
    end else if (t == T_LAST) begin
      n <= 3'd0;
    end else begin
      t <= t + 17'd1;
    end
  end

  always_comb begin
    pad_nxt = ~{b_c, b_b, b_r, b_l, b_d, b_u};
    if (sel_s) begin
      if (SIX && n == 3'd3) pad_nxt = ~{b_c, b_b, b_x, b_y, b_z, b_m};
    end else begin
      if (!SIX || n < 3'd3) pad_nxt = {~b_s, ~b_a, 2'b00, ~b_d, ~b_u};
      else if (n == 3'd3)   pad_nxt = {~b_s, ~b_a, 4'b0000};
      else                  pad_nxt = {~b_s, ~b_a, 4'b1111};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pad_out <= 6'b111111;
    else       pad_out <= pad_nxt;
  end

  assign phase = n;

endmodule

// File: tb/tb_md_pad_responder.sv
// Directed bench for md_pad_responder: a 6-button and a 3-button instance share
// stimulus; expectations go into a queue that a negedge monitor drains.
module tb_md_pad_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] btn;
  logic        mdsel;
  logic [5:0]  pad6, pad3;
  logic [2:0]  ph6, ph3;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic [5:0] p6;
    logic [5:0] p3;
    logic [2:0] ph;
  } exp_t;

  exp_t q[$];

  md_pad_responder #(.TIMEOUT(100), .SIX_BTN(1)) dut6 (
    .clk(clk), .reset(reset), .btn(btn), .mdsel(mdsel), .pad_out(pad6), .phase(ph6)
  );

  md_pad_responder #(.TIMEOUT(100), .SIX_BTN(0)) dut3 (
    .clk(clk), .reset(reset), .btn(btn), .mdsel(mdsel), .pad_out(pad3), .phase(ph3)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic cmp(input string tag, input string fld, input logic [5:0] got, input logic [5:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s %s: got %b want %b", tag, fld, got, want);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.tag, "pad6",   pad6,          e.p6);
      cmp(e.tag, "phase6", {3'b000, ph6}, {3'b000, e.ph});
      cmp(e.tag, "pad3",   pad3,          e.p3);
      cmp(e.tag, "phase3", {3'b000, ph3}, {3'b000, e.ph});
    end
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] p6, input logic [5:0] p3, input logic [2:0] ph);
    exp_t e;
    e.tag = tag; e.p6 = p6; e.p3 = p3; e.ph = ph;
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  // 20-cycle low then 20-cycle high; each level checked 4 cycles after its edge
  task automatic pulse(input string tag, input logic [5:0] l6, input logic [5:0] l3,
                       input logic [5:0] h6, input logic [5:0] h3, input logic [2:0] ph);
    mdsel = 1'b0;
    step(4);
    chk({tag, "_lo"}, l6, l3, ph);
    step(16);
    mdsel = 1'b1;
    step(4);
    chk({tag, "_hi"}, h6, h3, ph);
    step(16);
  endtask

  initial begin
    reset = 1'b1;
    mdsel = 1'b1;
    btn   = 12'h000;
    step(3);
    chk("rst", 6'b111111, 6'b111111, 3'd0);
    reset = 1'b0;
    step(1);
    chk("idle", 6'b111111, 6'b111111, 3'd0);
    btn = 12'h040;
    step(1);
    chk("btn_c", 6'b011111, 6'b011111, 3'd0);

    // 3-button read with S,B held
    btn = 12'h420;
    step(1);
    chk("3b_hi0", 6'b101111, 6'b101111, 3'd0);
    mdsel = 1'b0;
    step(3);
    chk("3b_lo", 6'b010011, 6'b010011, 3'd1);
    step(17);
    mdsel = 1'b1;
    step(3);
    chk("3b_hi", 6'b101111, 6'b101111, 3'd1);
    step(17);

    // 6-button sequence with M,X held
    do_reset();
    btn = 12'h880;
    pulse("s1", 6'b110011, 6'b110011, 6'b111111, 6'b111111, 3'd1);
    pulse("s2", 6'b110011, 6'b110011, 6'b111111, 6'b111111, 3'd2);
    pulse("s3", 6'b110000, 6'b110011, 6'b110110, 6'b111111, 3'd3);
    pulse("s4", 6'b111111, 6'b110011, 6'b111111, 6'b111111, 3'd4);
    pulse("s5", 6'b111111, 6'b110011, 6'b111111, 6'b111111, 3'd4);

    // Idle timeout: last edge clears t 3 cycles after the rise
    do_reset();
    pulse("t1", 6'b110011, 6'b110011, 6'b111111, 6'b111111, 3'd1);
    pulse("t2", 6'b110011, 6'b110011, 6'b111111, 6'b111111, 3'd2);
    step(82);
    chk("to_hold", 6'b111111, 6'b111111, 3'd2);
    step(1);
    chk("to_clr", 6'b111111, 6'b111111, 3'd0);
    pulse("r1", 6'b110011, 6'b110011, 6'b111111, 6'b111111, 3'd1);
    pulse("r2", 6'b110011, 6'b110011, 6'b111111, 6'b111111, 3'd2);
    pulse("r3", 6'b110000, 6'b110011, 6'b110110, 6'b111111, 3'd3);

    // Fall detected on the very cycle the timeout would fire
    do_reset();
    pulse("c1", 6'b110011, 6'b110011, 6'b111111, 6'b111111, 3'd1);
    pulse("c2", 6'b110011, 6'b110011, 6'b111111, 6'b111111, 3'd2);
    step(80);
    mdsel = 1'b0;
    step(2);
    chk("co_pre", 6'b111111, 6'b111111, 3'd2);
    step(1);
    chk("co_edge", 6'b110011, 6'b110011, 3'd3);
    step(1);
    chk("co_id", 6'b110000, 6'b110011, 3'd3);
    step(16);
    mdsel = 1'b1;
    step(20);

    // Every button pressed, then reset in the middle of a low phase
    do_reset();
    btn = 12'hFFF;
    pulse("f1", 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'd1);
    pulse("f2", 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'd2);
    pulse("f3", 6'b000000, 6'b000000, 6'b000000, 6'b000000, 3'd3);
    pulse("f4", 6'b001111, 6'b000000, 6'b000000, 6'b000000, 3'd4);
    pulse("f5", 6'b001111, 6'b000000, 6'b000000, 6'b000000, 3'd4);
    mdsel = 1'b0;
    step(4);
    chk("f6_lo", 6'b001111, 6'b000000, 3'd4);
    reset = 1'b1;
    step(1);
    chk("mid_rst", 6'b111111, 6'b111111, 3'd0);
    reset = 1'b0;
    step(3);
    chk("post_rst", 6'b000000, 6'b000000, 3'd1);

    step(2);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
